// File: rtl/rnd_burst_arbiter.sv
// rtl/rnd_burst_arbiter.sv - round-robin arbiter handing fixed-length bursts of PRNG words to requesters
module rnd_burst_arbiter #(
    parameter int N     = 4,
    parameter int W     = 32,
    parameter int BURST = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt,
    output logic [W-1:0] out_data,
    output logic [N-1:0] out_valid,
    input  logic [N-1:0] out_ready,
    output logic         out_last
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(BURST) + 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] idx_q, idx_d;

    logic [IW-1:0] sel;
    logic [IW-1:0] cand;
    logic          found;
    logic          busy;
    logic          last;
    logic          xfer;

    assign busy = (state_q == BUSY);
    assign last = busy && (cnt_q == CW'(BURST - 1));

    assign out_data  = in_data;
    assign gnt       = gnt_q;
    assign out_valid = busy ? (gnt_q & {N{in_valid}}) : '0;
    assign in_ready  = busy & (|(gnt_q & out_ready));
    assign out_last  = last;
    assign xfer      = in_valid & in_ready;

    // First requester at or above ptr, wrapping past N-1 back to 0.
    always_comb begin
        sel   = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            cand = IW'((int'(ptr_q) + k) % N);
            if (!found && req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (found) begin
                    state_d = BUSY;
                    gnt_d   = N'(1) << sel;
                    cnt_d   = '0;
                    idx_d   = sel;
                end
            end
            default: begin
                if (xfer) begin
                    if (last) begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        ptr_d   = IW'((int'(idx_q) + 1) % N);
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: tb/tb_rnd_burst_arbiter.sv
// tb/tb_rnd_burst_arbiter.sv - randomized check of two arbiter instances (BURST=4 and BURST=1) against a burst model
module tb_rnd_burst_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic [N-1:0] req = '0;
    logic [N-1:0] out_ready = '0;

    logic         in_ready4, in_ready1;
    logic [N-1:0] gnt4, gnt1;
    logic [W-1:0] out_data4, out_data1;
    logic [N-1:0] out_valid4, out_valid1;
    logic         out_last4, out_last1;

    int n_vec = 0;
    int n_err = 0;

    int m_owner[2];
    int m_done[2];
    int m_nxt[2];
    int m_burst[2] = '{4, 1};

    always #5 clk = ~clk;

    rnd_burst_arbiter #(.N(N), .W(W), .BURST(4)) u_b4 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready4),
        .req(req), .gnt(gnt4), .out_data(out_data4), .out_valid(out_valid4),
        .out_ready(out_ready), .out_last(out_last4)
    );

    rnd_burst_arbiter #(.N(N), .W(W), .BURST(1)) u_b1 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready1),
        .req(req), .gnt(gnt1), .out_data(out_data1), .out_valid(out_valid1),
        .out_ready(out_ready), .out_last(out_last1)
    );

    always @(negedge clk) begin
        if (!rst) begin
            assert ($onehot0(gnt4) && $onehot0(gnt1))
            else $error("FAIL onehot gnt4=%b gnt1=%b", gnt4, gnt1);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_owner[i] = -1;
            m_done[i]  = 0;
            m_nxt[i]   = 0;
        end
    endtask

    task automatic model_check(input int i, input logic [N-1:0] g, input logic [N-1:0] ov,
                               input logic ir, input logic ol, input logic [W-1:0] od);
        logic [N-1:0] eg;
        logic         own;
        own = (m_owner[i] >= 0);
        eg  = own ? N'(1 << m_owner[i]) : '0;
        chk($sformatf("b%0d_gnt", m_burst[i]), 64'(g), 64'(eg));
        chk($sformatf("b%0d_out_valid", m_burst[i]), 64'(ov), 64'(in_valid ? eg : '0));
        chk($sformatf("b%0d_in_ready", m_burst[i]), 64'(ir), 64'(own && out_ready[m_owner[i]]));
        chk($sformatf("b%0d_out_last", m_burst[i]), 64'(ol), 64'(own && m_done[i] == m_burst[i] - 1));
        if (own) chk($sformatf("b%0d_out_data", m_burst[i]), 64'(od), 64'(in_data));
    endtask

    task automatic model_step(input int i);
        if (m_owner[i] < 0) begin
            for (int k = 0; k < N; k++) begin
                if (m_owner[i] < 0 && req[(m_nxt[i] + k) % N]) begin
                    m_owner[i] = (m_nxt[i] + k) % N;
                    m_done[i]  = 0;
                end
            end
        end else if (in_valid && out_ready[m_owner[i]]) begin
            m_done[i]++;
            if (m_done[i] == m_burst[i]) begin
                m_nxt[i]   = (m_owner[i] + 1) % N;
                m_owner[i] = -1;
            end
        end
    endtask

    task automatic step(input logic [N-1:0] r, input logic v, input logic [N-1:0] rdy);
        @(negedge clk);
        req       = r;
        in_valid  = v;
        out_ready = rdy;
        in_data   = $urandom;
        #1;
        model_check(0, gnt4, out_valid4, in_ready4, out_last4, out_data4);
        model_check(1, gnt1, out_valid1, in_ready1, out_last1, out_data1);
        model_step(0);
        model_step(1);
    endtask

    // Asserts rst between edges and checks the outputs drop before any clock edge.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_gnt4", 64'(gnt4), 64'(0));
        chk("rst_gnt1", 64'(gnt1), 64'(0));
        chk("rst_in_ready4", 64'(in_ready4), 64'(0));
        chk("rst_in_ready1", 64'(in_ready1), 64'(0));
        chk("rst_out_valid4", 64'(out_valid4), 64'(0));
        chk("rst_out_last", 64'({out_last4, out_last1}), 64'(0));
        model_reset();
        @(posedge clk);
        @(negedge clk);
        req = '0;
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        do_reset();

        // Single requester: grant on cycle 1, words on 1-4, last on 4, idle on 5.
        for (int c = 0; c < 6; c++) begin
            step(4'b0001, 1'b1, 4'b1111);
            chk("single_gnt", 64'(gnt4), 64'((c >= 1 && c <= 4) ? 1 : 0));
            chk("single_last", 64'(out_last4), 64'(c == 4));
        end

        // Round robin with all requesting: 4-word bursts separated by one idle cycle.
        do_reset();
        for (int c = 0; c < 25; c++) begin
            step(4'b1111, 1'b1, 4'b1111);
            chk("rr_gnt", 64'(gnt4), 64'((c % 5 == 0) ? 0 : (1 << ((c / 5) % 4))));
        end

        // BURST=1 alternation between requesters 0 and 2.
        do_reset();
        for (int c = 0; c < 8; c++) begin
            step(4'b0101, 1'b1, 4'b1111);
            chk("b1_alt_gnt", 64'(gnt1), 64'((c % 2 == 0) ? 0 : (1 << (2 * ((c / 2) % 2)))));
            chk("b1_alt_last", 64'(out_last1), 64'(c % 2));
        end

        // Stall after word 2 for three cycles.
        do_reset();
        for (int c = 0; c < 8; c++) begin
            step(4'b0001, 1'b1, (c >= 3 && c <= 5) ? 4'b1110 : 4'b1111);
            if (c >= 3 && c <= 5) chk("stall_in_ready", 64'(in_ready4), 64'(0));
        end

        // Requester 2 drops its request after word 1; pointer then moves to 3.
        do_reset();
        for (int c = 0; c < 7; c++) begin
            step((c <= 1) ? 4'b0100 : (c >= 5 ? 4'b1111 : 4'b0000), 1'b1, 4'b1111);
            if (c >= 1 && c <= 4) chk("drop_gnt", 64'(gnt4), 64'(4'b0100));
        end
        chk("drop_next_gnt", 64'(gnt4), 64'(4'b1000));

        // Asynchronous reset during word 2 of a burst to requester 1.
        do_reset();
        for (int c = 0; c < 3; c++) step(4'b0010, 1'b1, 4'b1111);
        chk("pre_rst_gnt", 64'(gnt4), 64'(4'b0010));
        do_reset();
        step(4'b0011, 1'b1, 4'b1111);
        step(4'b0011, 1'b1, 4'b1111);
        chk("post_rst_gnt", 64'(gnt4), 64'(4'b0001));

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 79) == 0) do_reset();
            step(N'($urandom), ($urandom_range(0, 3) != 0), N'($urandom | $urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
